// File: rtl/mpc_dot_acc_sat.sv
// mpc_dot_acc_sat
//   Dot-product accumulator placed directly after the signed 21x14 DSP48
//   multiplier. Operand validity is tracked through the multiplier latency.
//   The products of one vector are summed in a saturating accumulator. At
//   end of vector the sum is rounded (half toward +inf), shifted right by
//   FRAC_SH and saturated to OUT_W, so it can re-enter the multiplier as an
//   'a' operand.
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   ce           clock enable shared with the multiplier
//   in_valid     operand pair presented to the multiplier this cycle
//   in_last      with in_valid: final term of the vector
//   p            signed product from the multiplier
//   out_valid    one-cycle pulse, result fields valid
//   out_data     rounded, saturated dot product
//   out_sat      out_data was clipped
//   acc_ovf      accumulator saturated during this vector
//   out_terms    number of terms accumulated in this vector
//   busy         a valid term is in flight or a partial sum is open
module mpc_dot_acc_sat #(
  parameter int P_W     = 35,
  parameter int ACC_W   = 41,
  parameter int OUT_W   = 21,
  parameter int FRAC_SH = 13,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [P_W-1:0]   p,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] out_terms,
  output logic             busy
);

  localparam int SH_W = ACC_W + 1 - FRAC_SH;
  localparam logic [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (FRAC_SH - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [MUL_LAT-1:0] vd, ld;
  logic [ACC_W-1:0]   acc, acc_next, p_ext;
  logic [ACC_W:0]     sum_wide, rnd;
  logic [SH_W-1:0]    sh;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               ovf_q, ovf_next, open_q;
  logic [OUT_W-1:0]   res_next;
  logic               sat_next;

  always_comb begin
    p_ext    = {{(ACC_W-P_W){p[P_W-1]}}, p};
    sum_wide = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};
    acc_next = acc;
    ovf_next = ovf_q;
    cnt_next = cnt;
    if (!open_q) begin
      // first term of a vector: load, never overflows (P_W < ACC_W)
      acc_next = p_ext;
      ovf_next = 1'b0;
      cnt_next = CNT_W'(1);
    end else begin
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
        ovf_next = 1'b1;
        acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_next = sum_wide[ACC_W-1:0];
      end
      if (cnt != '1) cnt_next = cnt + 1'b1;
    end
    // one guard bit keeps the rounding add from wrapping at +max
    rnd = {acc_next[ACC_W-1], acc_next} + RND_HALF;
    sh  = rnd[ACC_W:FRAC_SH];
    if ((&sh[SH_W-1:OUT_W-1]) || !(|sh[SH_W-1:OUT_W-1])) begin
      res_next = sh[OUT_W-1:0];
      sat_next = 1'b0;
    end else begin
      res_next = sh[SH_W-1] ? OUT_MIN : OUT_MAX;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vd        <= '0;
      ld        <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      open_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      acc_ovf   <= 1'b0;
      out_terms <= '0;
    end else begin
      out_valid <= 1'b0;
      if (ce) begin
        vd <= {vd[MUL_LAT-2:0], in_valid};
        ld <= {ld[MUL_LAT-2:0], in_valid & in_last};
        if (vd[MUL_LAT-1]) begin
          acc    <= acc_next;
          ovf_q  <= ovf_next;
          cnt    <= cnt_next;
          open_q <= !ld[MUL_LAT-1];
          if (ld[MUL_LAT-1]) begin
            out_valid <= 1'b1;
            out_data  <= res_next;
            out_sat   <= sat_next;
            acc_ovf   <= ovf_next;
            out_terms <= cnt_next;
          end
        end
      end
    end
  end

  assign busy = (|vd) | open_q;

endmodule

// File: tb/tb_mpc_dot_acc_sat.sv
module tb_mpc_dot_acc_sat;
  localparam int P_W = 35, ACC_W = 41, OUT_W = 21, FRAC_SH = 13, MUL_LAT = 3, CNT_W = 7;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [P_W-1:0] p;
  logic [P_W-1:0] pd [MUL_LAT];
  logic [P_W-1:0] pin = '0;
  logic out_valid, out_sat, acc_ovf, busy;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_terms;

  typedef struct {
    longint data;
    bit     sat;
    bit     ovf;
    int     terms;
    int     sent;
    bit     chk_lat;
  } exp_t;
  exp_t sb[$];

  int passed = 0, total = 0, cyc = 0;
  bit rand_ce = 1'b0;

  mpc_dot_acc_sat #(.P_W(P_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SH(FRAC_SH),
                    .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_last(in_last), .p(p),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .acc_ovf(acc_ovf),
    .out_terms(out_terms), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ce-gated multiplier pipeline: product appears MUL_LAT enabled edges later
  always @(posedge clk) if (ce) begin
    pd[0] <= pin;
    for (int i = 1; i < MUL_LAT; i++) pd[i] <= pd[i-1];
  end
  assign p = pd[MUL_LAT-1];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input longint t[$]);
    exp_t e;
    longint amax = (longint'(1) <<< (ACC_W-1)) - 1;
    longint amin = -(longint'(1) <<< (ACC_W-1));
    longint acc = 0, s, r;
    e.ovf = 1'b0;
    foreach (t[i]) begin
      if (i == 0) acc = t[i];
      else begin
        s = acc + t[i];
        if (s > amax) begin acc = amax; e.ovf = 1'b1; end
        else if (s < amin) begin acc = amin; e.ovf = 1'b1; end
        else acc = s;
      end
    end
    r = (acc + 4096) >>> FRAC_SH;
    e.sat = 1'b1;
    if (r > 1048575) e.data = 1048575;
    else if (r < -1048576) e.data = -1048576;
    else begin e.data = r; e.sat = 1'b0; end
    e.terms = (t.size() > 127) ? 127 : t.size();
    return e;
  endfunction

  // scoreboard consumer
  always @(negedge clk) if (!rst && out_valid) begin
    exp_t e;
    if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
    else begin
      e = sb.pop_front();
      chk("out_data", longint'($signed(out_data)), e.data);
      chk("out_sat", out_sat, e.sat);
      chk("acc_ovf", acc_ovf, e.ovf);
      chk("out_terms", out_terms, e.terms);
      if (e.chk_lat) chk("latency", cyc - e.sent, MUL_LAT);
    end
  end

  // one operand presentation; repeats until an enabled edge takes it
  task automatic step(input bit v, input bit l, input longint pv);
    bit took;
    do begin
      ce = rand_ce ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v; in_last = l; pin = P_W'(pv);
      took = ce;
      @(posedge clk); #1;
    end while (!took);
    in_valid = 1'b0; in_last = 1'b0; pin = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0);
  endtask

  task automatic send_vec(input longint t[$], input bit chk_lat);
    exp_t e;
    e = model(t);
    e.chk_lat = chk_lat;
    foreach (t[i]) step(1'b1, i == t.size() - 1, t[i]);
    e.sent = cyc;
    sb.push_back(e);
  endtask

  initial begin
    longint v[$];
    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // reset mid-vector with two terms in flight
    step(1'b1, 1'b0, 8192);
    step(1'b1, 1'b0, 8192);
    chk("busy_in_flight", busy, 1);
    rst = 1'b1; #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_terms", out_terms, 0);
    chk("midrst_out_sat", out_sat, 0);
    chk("midrst_acc_ovf", acc_ovf, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(8);

    // 4 x 1.0 in Q13, latency checked
    v = {8192, 8192, 8192, 8192};
    send_vec(v, 1'b1);
    idle(6);
    chk("hold_out_data", longint'($signed(out_data)), 4);

    // rounding boundaries, single-term vectors
    v = {4096};  send_vec(v, 1'b1); idle(4);
    v = {4095};  send_vec(v, 1'b1); idle(4);
    v = {-4096}; send_vec(v, 1'b1); idle(4);
    v = {-4097}; send_vec(v, 1'b1); idle(4);

    // output saturation both signs
    v = {(longint'(1) <<< 34) - 1, (longint'(1) <<< 34) - 1}; send_vec(v, 1'b0); idle(4);
    v = {-(longint'(1) <<< 34), -(longint'(1) <<< 34)};       send_vec(v, 1'b0); idle(4);

    // back-to-back vectors, ce=1 then random ce gaps
    v = {100000, -3000, 50000}; send_vec(v, 1'b1);
    v = {-8192, -8192};         send_vec(v, 1'b1);
    v = {12288};                send_vec(v, 1'b1);
    v = {-12289};               send_vec(v, 1'b1);
    idle(6);
    rand_ce = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = {};
      for (int j = 0; j <= k; j++) v.push_back(longint'($signed($urandom_range(0, 2000000))) - 1000000);
      send_vec(v, 1'b0);
    end
    rand_ce = 1'b0;
    idle(6);

    // accumulator overflow: 70 x -2^34
    v = {};
    for (int j = 0; j < 70; j++) v.push_back(-(longint'(1) <<< 34));
    send_vec(v, 1'b0);

    for (int k = 0; k < 200 && sb.size() != 0; k++) idle(1);
    chk("drain_timeout", sb.size(), 0);
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
